// File: rtl/shift_count_timer.sv
// shift_count_timer: after a start pulse, shifts in a 4-bit delay (MSB first)
// and then counts down (delay+1) steps of UNIT_CYCLES clocks each. When the
// count finishes it holds done until ack.
// Optional build macro SHIFT_COUNT_REARM_EN: an ack that arrives together with
// start_shifting in DONE starts a new capture directly, with no IDLE cycle.
module shift_count_timer #(
  parameter int unsigned UNIT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_shifting,
  input  logic       data,
  input  logic       ack,
  output logic       counting,
  output logic       done,
  output logic [3:0] count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] UNIT_LAST = 16'(UNIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  delay_q, delay_d;
  logic [1:0]  idx_q,   idx_d;
  logic [15:0] unit_q,  unit_d;

  // State and datapath registers; reset has priority over every input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      delay_q <= '0;
      idx_q   <= '0;
      unit_q  <= '0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      idx_q   <= idx_d;
      unit_q  <= unit_d;
    end
  end

  // Next-state logic: capture, per-unit countdown, and acknowledge handling.
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    idx_d   = idx_q;
    unit_d  = unit_q;
    unique case (state_q)
      IDLE: begin
        if (start_shifting) begin
          delay_d = {data, 3'b000};
          idx_d   = 2'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        delay_d[2'd3 - idx_q] = data;
        if (idx_q == 2'd3) begin
          idx_d   = '0;
          unit_d  = '0;
          state_d = COUNT;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      COUNT: begin
        if (unit_q == UNIT_LAST) begin
          unit_d = '0;
          if (delay_q == 4'd0) begin
            state_d = DONE;
          end else begin
            delay_d = delay_q - 4'd1;
          end
        end else begin
          unit_d = unit_q + 16'd1;
        end
      end
      DONE: begin
        if (ack) begin
`ifdef SHIFT_COUNT_REARM_EN
          if (start_shifting) begin
            delay_d = {data, 3'b000};
            idx_d   = 2'd1;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    counting = (state_q == COUNT);
    done     = (state_q == DONE);
    count    = (state_q == COUNT) ? delay_q : 4'd0;
  end

endmodule

// File: tb/tb_shift_count_timer.sv
// Testbench for shift_count_timer (UNIT_CYCLES=4): directed scenarios plus a
// randomized phase, all checked against a cycle-level behavioural model that
// tracks collected bits and remaining COUNT cycles arithmetically.
module tb_shift_count_timer;

  localparam int unsigned U = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_shifting = 1'b0;
  logic       data = 1'b0;
  logic       ack = 1'b0;
  logic       counting;
  logic       done;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: 0 idle, 1 collecting bits, 2 counting, 3 waiting for ack.
  int   m_mode = 0;
  bit   m_bits[$];
  int   m_rem = 0;

  shift_count_timer #(.UNIT_CYCLES(U)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_shifting (start_shifting),
    .data           (data),
    .ack            (ack),
    .counting       (counting),
    .done           (done),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input bit rst, input bit st, input bit d, input bit a);
    int dly;
    if (!rst) begin
      m_mode = 0;
      m_bits.delete();
      m_rem = 0;
      return;
    end
    case (m_mode)
      0: if (st) begin m_bits.delete(); m_bits.push_back(d); m_mode = 1; end
      1: begin
        m_bits.push_back(d);
        if (m_bits.size() == 4) begin
          dly = 8 * int'(m_bits[0]) + 4 * int'(m_bits[1]) + 2 * int'(m_bits[2]) + int'(m_bits[3]);
          m_rem = (dly + 1) * int'(U);
          m_mode = 2;
        end
      end
      2: begin
        m_rem--;
        if (m_rem == 0) m_mode = 3;
      end
      default: if (a) begin
`ifdef SHIFT_COUNT_REARM_EN
        if (st) begin m_bits.delete(); m_bits.push_back(d); m_mode = 1; end
        else m_mode = 0;
`else
        m_mode = 0;
`endif
      end
    endcase
  endfunction

  // One clock: drive inputs, advance model at the edge, check outputs after it.
  task automatic tick(input bit rst, input bit st, input bit d, input bit a);
    reset = rst; start_shifting = st; data = d; ack = a;
    @(posedge clk);
    model_step(rst, st, d, a);
    #1;
    check_eq("counting", int'(counting), (m_mode == 2) ? 1 : 0);
    check_eq("done",     int'(done),     (m_mode == 3) ? 1 : 0);
    check_eq("count",    int'(count),    (m_mode == 2) ? (m_rem - 1) / int'(U) : 0);
  endtask

  task automatic shift4(input bit [3:0] bits);
    tick(1, 1, bits[3], 0);
    tick(1, 0, bits[2], 0);
    tick(1, 0, bits[1], 0);
    tick(1, 0, bits[0], 0);
  endtask

  // Run through COUNT, optionally with start pulses, and check its length.
  task automatic run_count(input string tag, input int exp_dur, input bit noisy);
    int dur = 0;
    while (counting === 1'b1 && dur < 200) begin
      dur++;
      tick(1, noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check_eq(tag, dur, exp_dur);
    check_eq({tag, "_done"}, int'(done), 1);
  endtask

  initial begin
    // Reset state.
    tick(0, 0, 0, 0);
    tick(0, 1, 1, 1);
    check_eq("rst_counting", int'(counting), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_count", int'(count), 0);
    tick(1, 0, 0, 0);

    // Delay 1010: count 10 first, 44 cycles of COUNT.
    shift4(4'b1010);
    check_eq("d10_first", int'(count), 10);
    run_count("d10_dur", 44, 1'b0);
    tick(1, 0, 0, 1);

    // Delay 0: 4 cycles, then done holds through 20 cycles of no ack.
    shift4(4'b0000);
    check_eq("d0_first", int'(count), 0);
    run_count("d0_dur", 4, 1'b0);
    for (int i = 0; i < 20; i++) tick(1, 0, 0, 0);
    check_eq("d0_hold", int'(done), 1);
    tick(1, 0, 0, 1);
    check_eq("d0_ack", int'(done), 0);

    // Delay 15 with start pulses during COUNT: 64 cycles.
    shift4(4'b1111);
    check_eq("d15_first", int'(count), 15);
    run_count("d15_dur", 64, 1'b1);
    tick(1, 0, 0, 1);

    // Reset mid-COUNT; start on the reset edge is ignored.
    shift4(4'b0110);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0);
    tick(0, 1, 1, 0);
    check_eq("midrst_counting", int'(counting), 0);
    check_eq("midrst_count", int'(count), 0);
    tick(1, 0, 0, 0);
    check_eq("midrst_idle", int'(counting), 0);
    shift4(4'b0011);
    check_eq("d3_first", int'(count), 3);
    run_count("d3_dur", 16, 1'b0);

    // ack together with start and data 0,1,0,1 in DONE.
    tick(1, 1, 0, 1);
    tick(1, 0, 1, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 1, 0);
`ifdef SHIFT_COUNT_REARM_EN
    check_eq("rearm_count", int'(count), 5);
`else
    check_eq("rearm_counting", int'(counting), 0);
`endif
    for (int i = 0; i < 30; i++) tick(1, 0, 0, 1);

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_count_timer.md
SHIFT_COUNT_TIMER -- requirements
Module: shift_count_timer

Interface
REQ-001 Parameter: UNIT_CYCLES, default 1000, clk cycles per count step; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 start_shifting  input  1  one-cycle pulse from upstream pattern detector (pattern 1101 found).
REQ-005 data  input  1  serial bit stream, same line feeding the upstream detector.
REQ-006 ack  input  1  user acknowledge of timer completion.
REQ-007 counting  output  1  high while the timer is counting down.
REQ-008 done  output  1  high while waiting for ack after timeout.
REQ-009 count  output  4  remaining count steps while counting; 0 otherwise.

Function
REQ-010 States: IDLE, SHIFT, COUNT, DONE; encoding is implementation choice.
REQ-011 IDLE: on edge with start_shifting=1, capture data as delay[3] (MSB), set bit index 1, go to SHIFT; otherwise remain.
REQ-012 SHIFT: each edge captures data into delay[3-index] (MSB first); after delay[0] captured (4th bit total), go to COUNT with unit counter=0.
REQ-013 Net latency: 4 data bits captured on 4 consecutive edges, the first being the edge where start_shifting=1.
REQ-014 COUNT: counting=1, count=remaining delay; unit counter increments each cycle; at UNIT_CYCLES-1 it wraps to 0 and count decrements.
REQ-015 COUNT exit: when count=0 and unit counter=UNIT_CYCLES-1, go to DONE; total COUNT duration exactly (delay+1)*UNIT_CYCLES cycles.
REQ-016 delay=0 yields exactly UNIT_CYCLES cycles in COUNT; delay=15 yields 16*UNIT_CYCLES; UNIT_CYCLES=1 decrements every cycle.
REQ-017 DONE: done=1, counting=0, count=0; on edge with ack=1 go to IDLE; otherwise hold.
REQ-018 start_shifting ignored in SHIFT and COUNT; ack ignored outside DONE.
REQ-019 counting and done never high simultaneously; both registered-state decoded, no combinational path from inputs.
REQ-020 count=0 in IDLE, SHIFT, DONE.

Reset
REQ-021 reset=0 at any edge forces IDLE, delay=0, bit index=0, unit counter=0 regardless of state.
REQ-022 Reset values: counting=0, done=0, count=0, visible the cycle after the reset edge.
REQ-023 Reset mid-SHIFT or mid-COUNT discards partial delay; start_shifting on the reset-release edge is ignored (reset has priority).

Configuration
REQ-024 Macro SHIFT_COUNT_REARM_EN.
REQ-025 Defined: in DONE, edge with ack=1 and start_shifting=1 captures data as delay[3] and goes directly to SHIFT (no IDLE cycle).
REQ-026 Undefined: in DONE, ack=1 always goes to IDLE; start_shifting in the same cycle is ignored.
REQ-027 All other behaviour identical in both builds.

Verification (UNIT_CYCLES=4)
REQ-028 Reset, then start_shifting pulse with data 1,0,1,0 on 4 edges -> counting=1 next cycle, count=10, decrements every 4 cycles, COUNT lasts 44 cycles, then done=1.
REQ-029 Delay bits 0,0,0,0 -> COUNT lasts exactly 4 cycles with count=0, then done=1; hold ack=0 for 20 cycles -> done stays 1; ack=1 -> IDLE next cycle, done=0.
REQ-030 Delay 1,1,1,1 -> count=15 first COUNT cycle, COUNT lasts 64 cycles; start_shifting pulses during COUNT -> no effect on count or duration.
REQ-031 reset=0 at COUNT cycle 5 -> next cycle counting=0, done=0, count=0; new pulse with bits 0,0,1,1 -> count=3, 16-cycle COUNT.
REQ-032 In DONE, ack=1 with start_shifting=1 and data 0,1,0,1: with SHIFT_COUNT_REARM_EN -> COUNT with count=5 after 4 edges; without -> IDLE, no new count.
